// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - MM:SS BCD counter driven by a sampled slow_clk strobe
//
// Purpose:
//   Counts rising edges of slow_clk (sampled on clk, never used as a clock)
//   as a four-digit BCD MM:SS value from 00:00 up to <MIN_TENS_MAX>9:59,
//   then wraps to 00:00 with a one-clk rollover pulse.
//   Optional lap-hold freeze of the displayed value is enabled by defining
//   the macro STOPWATCH_LAP_EN; without it lap is ignored.
//
// Parameters:
//   MIN_TENS_MAX  highest minutes-tens digit value (1..9)
//
// Ports:
//   clk         in   1   system clock, single domain
//   reset       in   1   synchronous active-high reset
//   slow_clk    in   1   count strobe, clk-synchronous, rising edge counts
//   lap         in   1   debounced lap button, level-high
//   digits      out  16  {min_tens, min_ones, sec_tens, sec_ones}
//   rollover    out  1   one-clk pulse on wrap to 00:00
//   lap_active  out  1   high while the display is frozen

module bcd_time_counter #(
  parameter int MIN_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slow_clk,
  input  logic        lap,
  output logic [15:0] digits,
  output logic        rollover,
  output logic        lap_active
);

  localparam logic [3:0] MT_LAST = 4'(MIN_TENS_MAX);

  logic        slow_clk_q;
  logic        tick;
  logic [15:0] count;
  logic [15:0] count_inc;
  logic        wrap;

  // slow_clk_q resets high so a strobe already high at release is not an edge.
  assign tick = slow_clk & ~slow_clk_q;

  // BCD carry chain. ">=" comparisons make each digit self-correcting even
  // though no out-of-range value is reachable from reset.
  always_comb begin
    count_inc = count;
    wrap      = 1'b0;
    if (count[3:0] < 4'd9) begin
      count_inc[3:0] = count[3:0] + 4'd1;
    end else begin
      count_inc[3:0] = 4'd0;
      if (count[7:4] < 4'd5) begin
        count_inc[7:4] = count[7:4] + 4'd1;
      end else begin
        count_inc[7:4] = 4'd0;
        if (count[11:8] < 4'd9) begin
          count_inc[11:8] = count[11:8] + 4'd1;
        end else begin
          count_inc[11:8] = 4'd0;
          if (count[15:12] < MT_LAST) begin
            count_inc[15:12] = count[15:12] + 4'd1;
          end else begin
            count_inc[15:12] = 4'd0;
            wrap             = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slow_clk_q <= 1'b1;
      count      <= 16'h0000;
      rollover   <= 1'b0;
    end else begin
      slow_clk_q <= slow_clk;
      rollover   <= tick & wrap;
      if (tick) begin
        count <= count_inc;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  typedef enum logic {LIVE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state;
  logic        lap_q;
  logic        lap_edge;
  logic [15:0] snapshot;

  assign lap_edge = lap & ~lap_q;

  // The snapshot takes count as registered before this edge, so a tick on
  // the same edge is excluded from the frozen value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LIVE;
      lap_q    <= 1'b1;
      snapshot <= 16'h0000;
    end else begin
      lap_q <= lap;
      if (lap_edge) begin
        case (state)
          LIVE: begin
            state    <= HOLD;
            snapshot <= count;
          end
          HOLD: begin
            state <= LIVE;
          end
          default: state <= LIVE;
        endcase
      end
    end
  end

  assign lap_active = (state == HOLD);
  assign digits     = lap_active ? snapshot : count;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign digits     = count;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - scoreboard bench for bcd_time_counter

module tb_bcd_time_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        slow_clk = 1'b0;
  logic        lap = 1'b0;
  logic [15:0] digits;
  logic        rollover;
  logic        lap_active;

  bcd_time_counter #(.MIN_TENS_MAX(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .slow_clk   (slow_clk),
    .lap        (lap),
    .digits     (digits),
    .rollover   (rollover),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] d;
    logic        r;
    logic        la;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // Independent reference: seconds as an integer, converted to BCD on demand.
  int          secs = 0;
  logic        exp_la = 1'b0;
  logic [15:0] snap = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic push(input string name, input logic [15:0] d, input logic r, input logic la);
    exp_t e;
    e.due  = cyc;
    e.d    = d;
    e.r    = r;
    e.la   = la;
    e.name = name;
    q.push_back(e);
  endtask

  function automatic logic [15:0] shown();
    return exp_la ? snap : to_bcd(secs);
  endfunction

  // Monitor: compares every expectation whose sample cycle has arrived.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (digits === e.d && rollover === e.r && lap_active === e.la) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got digits=%04h rollover=%b lap_active=%b, expected digits=%04h rollover=%b lap_active=%b",
                 e.name, digits, rollover, lap_active, e.d, e.r, e.la);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    secs   = 0;
    exp_la = 1'b0;
    snap   = 16'h0000;
    push("reset_state", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // One 1-clk-high strobe per 4 clk; checks the edge it lands on and the next.
  task automatic pulse(input string name);
    logic wrapped;
    push({name, "_pre"}, shown(), 1'b0, exp_la);
    slow_clk = 1'b1;
    step();
    secs    = (secs + 1) % 3600;
    wrapped = (secs == 0);
    push(name, shown(), wrapped, exp_la);
    slow_clk = 1'b0;
    step();
    push({name, "_post"}, shown(), 1'b0, exp_la);
    repeat (2) step();
  endtask

  initial begin
    // Reset with slow_clk already high: release must not count.
    slow_clk = 1'b1;
    do_reset();
    step();
    push("high_at_release", 16'h0000, 1'b0, 1'b0);
    step();
    push("high_at_release2", 16'h0000, 1'b0, 1'b0);
    slow_clk = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 10; i++) pulse("count");
    push("ten_pulses", 16'h0010, 1'b0, 1'b0);
    for (int i = 10; i < 70; i++) pulse("count");
    push("seventy_pulses", 16'h0110, 1'b0, 1'b0);
    for (int i = 70; i < 3599; i++) pulse("count");
    push("at_5959", 16'h5959, 1'b0, 1'b0);

    // Wrap: explicit constants on top of the model-driven pulse checks.
    slow_clk = 1'b1;
    step();
    secs = 0;
    push("wrap_value", 16'h0000, 1'b1, 1'b0);
    slow_clk = 1'b0;
    step();
    push("rollover_one_clk", 16'h0000, 1'b0, 1'b0);
    repeat (2) step();

    // Level held high for 20 clk counts once.
    slow_clk = 1'b1;
    step();
    secs = 1;
    push("level_first", 16'h0001, 1'b0, 1'b0);
    repeat (19) step();
    push("level_held", 16'h0001, 1'b0, 1'b0);
    slow_clk = 1'b0;
    repeat (2) step();
    push("level_released", 16'h0001, 1'b0, 1'b0);

    // Bring to 01:23, then reset coincident with a strobe edge.
    for (int i = 1; i < 83; i++) pulse("to_0123");
    push("at_0123", 16'h0123, 1'b0, 1'b0);
    reset    = 1'b1;
    slow_clk = 1'b1;
    step();
    secs = 0;
    push("reset_vs_tick", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    push("after_reset_high", 16'h0000, 1'b0, 1'b0);
    slow_clk = 1'b0;
    step();
    pulse("after_reset");

`ifdef STOPWATCH_LAP_EN
    do_reset();
    for (int i = 0; i < 42; i++) pulse("to_0042");
    lap = 1'b1;
    step();
    snap   = to_bcd(secs);
    exp_la = 1'b1;
    push("lap_enter", 16'h0042, 1'b0, 1'b1);
    lap = 1'b0;
    step();
    for (int i = 0; i < 5; i++) pulse("held");
    push("held_value", 16'h0042, 1'b0, 1'b1);
    lap = 1'b1;
    step();
    exp_la = 1'b0;
    push("lap_exit", 16'h0047, 1'b0, 1'b0);
    lap = 1'b0;
    step();
`else
    lap = 1'b1;
    step();
    push("lap_ignored", to_bcd(secs), 1'b0, 1'b0);
    lap = 1'b0;
    step();
    pulse("after_lap");
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations never sampled, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
